// File: rtl/if_fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, handshakes with a
// variable-latency instruction memory and hands words to decode.
module if_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic [PC_WIDTH-1:0] branch_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_data,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    RST_WAIT,
    FETCH,
    HOLD
  } state_t;

  localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);

  state_t state;
  state_t state_nxt;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                valid_nxt;
  logic [PC_WIDTH-1:0] instr_nxt;
  logic [PC_WIDTH-1:0] pc_out_nxt;
  logic                redirect_pending;
  logic                pend_nxt;
  logic [PC_WIDTH-1:0] pending_target;
  logic [PC_WIDTH-1:0] ptgt_nxt;

  logic                redirect;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] br_target;
  logic [PC_WIDTH-1:0] j_target;
  logic [PC_WIDTH-1:0] target;

  assign redirect  = jump | branch_taken;
  assign seq_pc    = branch_pc + FOUR;
  assign br_target = seq_pc + {branch_offset[PC_WIDTH-3:0], 2'b00};
  assign j_target  = {seq_pc[PC_WIDTH-1:28], jump_index, 2'b00};
  assign target    = jump ? j_target : br_target;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign busy      = imem_req & ~imem_ack;

  always_ff @(posedge clk) begin
    if (reset) state <= RST_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = instr_valid;
    instr_nxt  = instruction;
    pc_out_nxt = pc_out;
    pend_nxt   = redirect_pending;
    ptgt_nxt   = pending_target;
    unique case (state)
      RST_WAIT: begin
        state_nxt = FETCH;
        valid_nxt = 1'b0;
        if (redirect) pc_nxt = target;
      end
      FETCH: begin
        valid_nxt = 1'b0;
        if (redirect && imem_ack) begin
          pc_nxt   = target;
          pend_nxt = 1'b0;
        end else if (redirect) begin
          // address must stay put until the ack, so park the target
          ptgt_nxt = target;
          pend_nxt = 1'b1;
        end else if (imem_ack && redirect_pending) begin
          pc_nxt   = pending_target;
          pend_nxt = 1'b0;
        end else if (imem_ack) begin
          instr_nxt  = imem_data;
          pc_out_nxt = pc;
          valid_nxt  = 1'b1;
          pc_nxt     = pc + FOUR;
          if (stall) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!stall) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = RST_WAIT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_PC[PC_WIDTH-1:0];
      instr_valid      <= 1'b0;
      instruction      <= '0;
      pc_out           <= '0;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else begin
      pc               <= pc_nxt;
      instr_valid      <= valid_nxt;
      instruction      <= instr_nxt;
      pc_out           <= pc_out_nxt;
      redirect_pending <= pend_nxt;
      pending_target   <= ptgt_nxt;
    end
  end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed bench for if_fetch_sequencer with a latency-programmable
// instruction memory model.
module tb_if_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] branch_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          wait_cnt = 0;
  logic        ack_force = 1'b0;

  always #5 clk = ~clk;

  if_fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .branch_pc(branch_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instruction(instruction),
    .pc_out(pc_out), .busy(busy)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  assign imem_ack  = (imem_req && (wait_cnt == lat - 1)) || ack_force;
  assign imem_data = mdata(imem_addr);

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = '0; jump_index = '0; branch_pc = '0;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_wait_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    chk("first_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("zw_valid", {31'b0, instr_valid}, 32'd1);
      chk("zw_pc_out", pc_out, 32'(4 * i));
      chk("zw_instr", instruction, mdata(32'(4 * i)));
    end
    chk("zw_addr", imem_addr, 32'd16);

    lat = 3;
    do_reset();
    chk("l3_addr_a", imem_addr, 32'd0);
    chk("l3_busy_a", {31'b0, busy}, 32'd1);
    chk("l3_valid_a", {31'b0, instr_valid}, 32'd0);
    step();
    chk("l3_addr_b", imem_addr, 32'd0);
    chk("l3_busy_b", {31'b0, busy}, 32'd1);
    step();
    chk("l3_addr_c", imem_addr, 32'd0);
    chk("l3_busy_c", {31'b0, busy}, 32'd0);
    step();
    chk("l3_valid_d", {31'b0, instr_valid}, 32'd1);
    chk("l3_pc_out_d", pc_out, 32'd0);
    chk("l3_addr_d", imem_addr, 32'd4);
    step();
    chk("l3_pulse_e", {31'b0, instr_valid}, 32'd0);
    step();
    step();
    chk("l3_valid_g", {31'b0, instr_valid}, 32'd1);
    chk("l3_pc_out_g", pc_out, 32'd4);

    lat = 1;
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_valid", {31'b0, instr_valid}, 32'd1);
      chk("st_pc_out", pc_out, 32'h8);
      chk("st_instr", instruction, mdata(32'h8));
      chk("st_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("st_release_req", {31'b0, imem_req}, 32'd0);
    step();
    chk("st_rel_valid", {31'b0, instr_valid}, 32'd0);
    chk("st_rel_req", {31'b0, imem_req}, 32'd1);
    chk("st_rel_addr", imem_addr, 32'hC);
    step();
    chk("st_next_pc", pc_out, 32'hC);

    do_reset();
    branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = -32'sd2;
    step();
    branch_taken = 1'b0;
    chk("br_squash", {31'b0, instr_valid}, 32'd0);
    chk("br_addr", imem_addr, 32'hC);
    step();
    chk("br_pc_out", pc_out, 32'hC);
    chk("br_instr", instruction, mdata(32'hC));
    jump = 1'b1; branch_taken = 1'b1; branch_offset = 32'd5;
    branch_pc = 32'h2000_0000; jump_index = 26'h40;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    chk("jb_prio_addr", imem_addr, 32'h2000_0100);
    chk("jb_squash", {31'b0, instr_valid}, 32'd0);

    lat = 3;
    do_reset();
    jump = 1'b1; branch_pc = 32'hF000_0000; jump_index = 26'h100;
    step();
    jump = 1'b0;
    chk("jp_hold_b", imem_addr, 32'd0);
    chk("jp_valid_b", {31'b0, instr_valid}, 32'd0);
    step();
    chk("jp_hold_c", imem_addr, 32'd0);
    step();
    chk("jp_discard", {31'b0, instr_valid}, 32'd0);
    chk("jp_target", imem_addr, 32'hF000_0400);
    chk("jp_busy", {31'b0, busy}, 32'd1);
    branch_taken = 1'b1; branch_pc = 32'h100; branch_offset = 32'd3;
    step();
    branch_taken = 1'b0;
    jump = 1'b1; branch_pc = 32'h200; jump_index = 26'h80;
    step();
    jump = 1'b0;
    chk("ow_hold", imem_addr, 32'hF000_0400);
    branch_taken = 1'b1; branch_pc = 32'h300; branch_offset = 32'd1;
    step();
    branch_taken = 1'b0;
    chk("ow_new_wins", imem_addr, 32'h308);
    chk("ow_valid", {31'b0, instr_valid}, 32'd0);

    lat = 1;
    do_reset();
    branch_taken = 1'b1; branch_pc = 32'h30; branch_offset = 32'd3;
    step();
    branch_taken = 1'b0;
    lat = 3;
    #1;
    chk("mr_addr", imem_addr, 32'h40);
    chk("mr_busy", {31'b0, busy}, 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk("mr_valid", {31'b0, instr_valid}, 32'd0);
    chk("mr_pc", imem_addr, 32'd0);
    ack_force = 1'b1;
    step();
    ack_force = 1'b0;
    reset = 1'b0;
    chk("mr_late_ack", {31'b0, instr_valid}, 32'd0);
    step();
    chk("mr_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("mr_fetch_addr", imem_addr, 32'd0);
    chk("mr_fetch_valid", {31'b0, instr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
